bram2be_init: RTL and testbench
===============================

# bram2be_init

Single-clock, true dual-port block RAM with per-chunk byte enables, a selectable read-during-write mode, per-port read-valid flags, same-address write arbitration, and a hardware clear engine that sweeps the array after reset. It replaces hand-instantiated dual-port BE RAMs in the GPIOCP wrapper wherever a known-zeroed memory and explicit output validity are needed without a separate init controller.

## Interface
- ADDR_WIDTH, 1: address width, both ports.
- DATA_WIDTH, 8: word width.
- CHUNKSIZE, 8: bits per byte-enable chunk.
- WE_WIDTH, 1: enable bits per port. DATA_WIDTH == WE_WIDTH*CHUNKSIZE is required.
- MEMSIZE, 2: number of words, at most 2^ADDR_WIDTH.
- PIPELINED, 0: 0 gives 1-cycle read latency; 1 gives 2-cycle.
- RDW_MODE, 0: same-port read-during-write. 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
- CLEAR_ON_RESET, 1: 1 means the clear engine writes INIT_VALUE to every word after reset.
- INIT_VALUE, 0: DATA_WIDTH-bit word used by the clear engine.
- CLK, in, 1: the single clock. All logic is posedge CLK.
- RST_N, in, 1: reset. Synchronous, active-low.
- ENA / ENB, in, 1: port enable.
- WEA / WEB, in, WE_WIDTH: chunk write enables. Chunk j is bits [j*CHUNKSIZE +: CHUNKSIZE].
- ADDRA / ADDRB, in, ADDR_WIDTH: word address.
- DIA / DIB, in, DATA_WIDTH: write data.
- DOA / DOB, out, DATA_WIDTH: read data.
- VALA / VALB, out, 1: DOA / DOB holds the result of an accepted operation.
- RDY, out, 1: ports accept operations.
- COLL, out, 1: one-cycle pulse for a same-address dual write.

## Operation
- FSM states are RESET, CLEAR and READY.
  - RESET: entered while RST_N is 0. The next state is CLEAR if CLEAR_ON_RESET, otherwise READY.
  - CLEAR: an internal counter writes INIT_VALUE to address 0..MEMSIZE-1, one word per cycle. After the last word the FSM goes to READY.
  - READY: terminal state.
- RST_N low in any state, including mid-CLEAR, returns to RESET and restarts the clear from address 0.
- Memory contents are not otherwise affected by reset. With CLEAR_ON_RESET=0, contents are undefined: X in simulation, no initial file load.
- RDY is 1 only in READY. While RDY=0, ENA/ENB are ignored: no write, no VAL.
- An operation is accepted when RDY & EN. It is a write if |WE, else a read.
- Write: only chunks with WE[j]=1 are replaced; other chunks keep their stored value.
- Read data for an accepted write, same port:
  - WRITE_FIRST: DO gets the merged new word and VAL is set.
  - READ_FIRST: DO gets the pre-write word and VAL is set.
  - NO_CHANGE: DO and VAL are unchanged by the write, and the VAL pipeline gets 0.
- Cross-port read of an address being written by the other port in the same cycle returns the pre-write word, in all modes.
- Both ports write the same address in the same cycle:
  - Each chunk is taken from port B if WEB[j], else from port A if WEA[j], else the old value.
  - COLL pulses 1 for one cycle, aligned with the first output stage.
  - Each port's DO follows its own RDW_MODE using the final merged word (WRITE_FIRST) or the old word (READ_FIRST).
- Address >= MEMSIZE: the write is dropped, a read returns 0, and VAL is still set.
- With no accepted operation, DO holds its last value and VAL goes 0.

## Timing
- Reset values, while RST_N=0 and the cycle after: DOA=DOB=0, VALA=VALB=0, RDY=0, COLL=0.
- CLEAR_ON_RESET=1: RDY rises MEMSIZE+1 cycles after the first clock edge with RST_N=1.
- CLEAR_ON_RESET=0: RDY rises 1 cycle after the first clock edge with RST_N=1.
- PIPELINED=0: an operation accepted at edge t gives DO/VAL valid after edge t+1. A write at t is visible to a read accepted at t+1.
- PIPELINED=1: one extra register stage on DO, VAL and COLL, giving latency 2. VAL and COLL pipeline stages reset to 0. Both stages advance every cycle, so there is no stall.
- Back-to-back operations on each port every cycle are supported at full throughput.

## Test plan
- Clear sweep: MEMSIZE=16, INIT_VALUE=0xA5, RST_N low 3 cycles then high.
  - RDY rises exactly 17 cycles later.
  - Reads of addresses 0..15 return 0xA5 with VALA=1, one cycle after each.
- Reset mid-clear: drop RST_N at clear address 7, then release.
  - The sweep restarts at 0 and RDY rises 17 cycles after release.
  - Ops issued while RDY=0 give VAL=0 and leave memory unchanged.
- Byte enables, DATA_WIDTH=32, CHUNKSIZE=8: write 0x11223344, then write 0xAABBCCDD with WEA=0b0101.
  - A read returns 0x11BB33DD.
- RDW modes: word holds 0x0F, then A writes 0xF0 with full enables.
  - WRITE_FIRST: DOA=0xF0, VALA=1.
  - READ_FIRST: DOA=0x0F, VALA=1.
  - NO_CHANGE: DOA holds its prior value and VALA=0.
- Dual-write collision at address 3: A writes 0x1111 and B writes 0x2222, WEA=2'b11, WEB=2'b01.
  - Memory holds 0x1122 and COLL pulses once.
  - A concurrent cross-port read of address 3 returns the old word.
- PIPELINED=1 streaming: reads to addresses 0..7 on consecutive cycles.
  - DOA/VALA lag by exactly 2 cycles with no bubbles.
  - An out-of-range address returns 0 with VALA=1.

Source files
------------

// File: rtl/bram2be_init.sv
// Dual-port byte-enable block RAM with a post-reset clear sweep, per-port read
// valids, same-address write arbitration (B wins per chunk) and optional output register.
module bram2be_init #(
   parameter int                    ADDR_WIDTH     = 1,
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    CHUNKSIZE      = 8,
   parameter int                    WE_WIDTH       = 1,
   parameter int                    MEMSIZE        = 2,
   parameter int                    PIPELINED      = 0,
   parameter int                    RDW_MODE       = 0,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  ENA,
   input  logic                  ENB,
   input  logic [WE_WIDTH-1:0]   WEA,
   input  logic [WE_WIDTH-1:0]   WEB,
   input  logic [ADDR_WIDTH-1:0] ADDRA,
   input  logic [ADDR_WIDTH-1:0] ADDRB,
   input  logic [DATA_WIDTH-1:0] DIA,
   input  logic [DATA_WIDTH-1:0] DIB,
   output logic [DATA_WIDTH-1:0] DOA,
   output logic [DATA_WIDTH-1:0] DOB,
   output logic                  VALA,
   output logic                  VALB,
   output logic                  RDY,
   output logic                  COLL
);
   localparam int IW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

   typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

   state_t                state_q, state_d;
   logic                  rst_n_q, rst_n_d;
   logic [IW-1:0]         clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [MEMSIZE];

   logic [DATA_WIDTH-1:0] doa1_q, doa1_d, dob1_q, dob1_d;
   logic                  vala1_q, vala1_d, valb1_q, valb1_d, coll1_q, coll1_d;

   logic                  acc_a, acc_b, wr_a, wr_b, inr_a, inr_b, same;
   logic [IW-1:0]         idx_a, idx_b;
   logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b;

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                   input logic [DATA_WIDTH-1:0] din,
                                                   input logic [WE_WIDTH-1:0]   we);
      merge = old;
      for (int j = 0; j < WE_WIDTH; j++)
         if (we[j]) merge[j*CHUNKSIZE +: CHUNKSIZE] = din[j*CHUNKSIZE +: CHUNKSIZE];
   endfunction

   // Returns {valid, data} for one port's first output stage.
   function automatic logic [DATA_WIDTH:0] rd_sel(input logic acc, input logic wr,
                                                  input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] nw,
                                                  input logic [DATA_WIDTH-1:0] hold);
      rd_sel = {1'b0, hold};
      if (acc) begin
         if (!wr)                rd_sel = {1'b1, old};
         else if (RDW_MODE == 0) rd_sel = {1'b1, nw};
         else if (RDW_MODE == 1) rd_sel = {1'b1, old};
      end
   endfunction

   assign RDY = (state_q == ST_READY);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      rst_n_d   = RST_N;
      case (state_q)
         ST_RESET: begin
            clr_cnt_d = '0;
            // Hold one extra cycle after release so the sweep starts from a settled reset.
            if (rst_n_q) state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IW'(MEMSIZE - 1)) state_d = ST_READY;
         end
         ST_READY: ;
         default:  state_d = ST_RESET;
      endcase
   end

   always_comb begin
      acc_a = RDY & ENA & RST_N;
      acc_b = RDY & ENB & RST_N;
      wr_a  = acc_a & (|WEA);
      wr_b  = acc_b & (|WEB);
      inr_a = 32'(ADDRA) < MEMSIZE;
      inr_b = 32'(ADDRB) < MEMSIZE;
      same  = (ADDRA == ADDRB);
      idx_a = IW'(ADDRA);
      idx_b = IW'(ADDRB);
      old_a = inr_a ? mem_q[idx_a] : '0;
      old_b = inr_b ? mem_q[idx_b] : '0;

      // Own-port write-first view includes the other port's chunks on a collision.
      new_a = merge(old_a, DIA, WEA);
      if (wr_b && same) new_a = merge(new_a, DIB, WEB);
      if (!inr_a) new_a = '0;
      new_b = old_b;
      if (wr_a && same) new_b = merge(new_b, DIA, WEA);
      new_b = merge(new_b, DIB, WEB);
      if (!inr_b) new_b = '0;

      {vala1_d, doa1_d} = rd_sel(acc_a, wr_a, old_a, new_a, doa1_q);
      {valb1_d, dob1_d} = rd_sel(acc_b, wr_b, old_b, new_b, dob1_q);
      coll1_d = wr_a & wr_b & inr_a & same;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= ST_RESET;
         rst_n_q   <= 1'b0;
         clr_cnt_q <= '0;
         doa1_q    <= '0;
         dob1_q    <= '0;
         vala1_q   <= 1'b0;
         valb1_q   <= 1'b0;
         coll1_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_n_q   <= rst_n_d;
         clr_cnt_q <= clr_cnt_d;
         doa1_q    <= doa1_d;
         dob1_q    <= dob1_d;
         vala1_q   <= vala1_d;
         valb1_q   <= valb1_d;
         coll1_q   <= coll1_d;
      end
   end

   // Port B is written after port A so it wins chunk-by-chunk on a shared address.
   always_ff @(posedge CLK) begin
      if (RST_N) begin
         if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= INIT_VALUE;
         end else begin
            for (int j = 0; j < WE_WIDTH; j++) begin
               if (wr_a && inr_a && WEA[j])
                  mem_q[idx_a][j*CHUNKSIZE +: CHUNKSIZE] <= DIA[j*CHUNKSIZE +: CHUNKSIZE];
               if (wr_b && inr_b && WEB[j])
                  mem_q[idx_b][j*CHUNKSIZE +: CHUNKSIZE] <= DIB[j*CHUNKSIZE +: CHUNKSIZE];
            end
         end
      end
   end

   if (PIPELINED != 0) begin : g_pipe
      logic [DATA_WIDTH-1:0] doa2_q, dob2_q;
      logic                  vala2_q, valb2_q, coll2_q;

      always_ff @(posedge CLK) begin
         if (!RST_N) begin
            doa2_q  <= '0;
            dob2_q  <= '0;
            vala2_q <= 1'b0;
            valb2_q <= 1'b0;
            coll2_q <= 1'b0;
         end else begin
            doa2_q  <= doa1_q;
            dob2_q  <= dob1_q;
            vala2_q <= vala1_q;
            valb2_q <= valb1_q;
            coll2_q <= coll1_q;
         end
      end

      assign DOA  = doa2_q;
      assign DOB  = dob2_q;
      assign VALA = vala2_q;
      assign VALB = valb2_q;
      assign COLL = coll2_q;
   end else begin : g_flat
      assign DOA  = doa1_q;
      assign DOB  = dob1_q;
      assign VALA = vala1_q;
      assign VALB = valb1_q;
      assign COLL = coll1_q;
   end
endmodule

// File: tb/tb_bram2be_init.sv
// Bench for bram2be_init: three instances (write-first, pipelined read-first, no-change)
// share stimulus; a vector table feeds per-instance scoreboards checked at each latency.
module tb_bram2be_init;
   localparam int AW = 5, DW = 32, WW = 4;
   localparam logic [DW-1:0] A5 = 32'h0000_00A5;

   logic          clk = 1'b0;
   logic          rst_n, ena, enb;
   logic [WW-1:0] wea, web;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dia, dib;
   logic [DW-1:0] doa [3];
   logic [DW-1:0] dob [3];
   logic          vala [3], valb [3], rdy [3], coll [3];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      bram2be_init #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNKSIZE(8), .WE_WIDTH(WW), .MEMSIZE(16),
         .PIPELINED((k == 1) ? 1 : 0), .RDW_MODE(k), .CLEAR_ON_RESET(1), .INIT_VALUE(A5)
      ) u_dut (
         .CLK(clk), .RST_N(rst_n), .ENA(ena), .ENB(enb), .WEA(wea), .WEB(web),
         .ADDRA(addra), .ADDRB(addrb), .DIA(dia), .DIB(dib),
         .DOA(doa[k]), .DOB(dob[k]), .VALA(vala[k]), .VALB(valb[k]),
         .RDY(rdy[k]), .COLL(coll[k])
      );
   end

   // Expected values indexed 0 = write-first, 1 = read-first (pipelined), 2 = no-change.
   typedef struct {
      logic          ena, enb;
      logic [WW-1:0] wea, web;
      logic [AW-1:0] addra, addrb;
      logic [DW-1:0] dia, dib;
      logic [0:2][DW-1:0] doa, dob;
      logic [0:2]    vala, valb;
      logic          coll, cdb;
   } vec_t;

   typedef struct {
      int            due, idx;
      logic [DW-1:0] doa, dob;
      logic          vala, valb, coll, cdb;
   } exp_t;

   vec_t tbl[$];
   exp_t q0[$], q1[$], q2[$];
   int   errs = 0, checks = 0, cyc = 0;

   function automatic vec_t mk(input logic ea, input logic [WW-1:0] wa, input logic [AW-1:0] aa,
                               input logic [DW-1:0] da, input logic eb, input logic [WW-1:0] wb,
                               input logic [AW-1:0] ab, input logic [DW-1:0] db,
                               input logic [DW-1:0] xa0, input logic [DW-1:0] xa1,
                               input logic [DW-1:0] xa2, input logic [0:2] va,
                               input logic [DW-1:0] xb0, input logic [DW-1:0] xb1,
                               input logic [DW-1:0] xb2, input logic [0:2] vb,
                               input logic cl, input logic cb);
      vec_t v;
      v.ena = ea; v.wea = wa; v.addra = aa; v.dia = da;
      v.enb = eb; v.web = wb; v.addrb = ab; v.dib = db;
      v.doa = {xa0, xa1, xa2}; v.vala = va;
      v.dob = {xb0, xb1, xb2}; v.valb = vb;
      v.coll = cl; v.cdb = cb;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cmp(input int k, input exp_t e);
      string p;
      p = $sformatf("v%0d u%0d", e.idx, k);
      chk({p, " doa"}, doa[k], e.doa);
      chk({p, " vala"}, 32'(vala[k]), 32'(e.vala));
      if (e.cdb) chk({p, " dob"}, dob[k], e.dob);
      chk({p, " valb"}, 32'(valb[k]), 32'(e.valb));
      chk({p, " coll"}, 32'(coll[k]), 32'(e.coll));
   endtask

   task automatic tick;
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (q0.size() > 0 && q0[0].due <= cyc) begin e = q0.pop_front(); cmp(0, e); end
      while (q1.size() > 0 && q1[0].due <= cyc) begin e = q1.pop_front(); cmp(1, e); end
      while (q2.size() > 0 && q2[0].due <= cyc) begin e = q2.pop_front(); cmp(2, e); end
   endtask

   task automatic drive(input vec_t v, input int i);
      exp_t e;
      ena = v.ena; wea = v.wea; addra = v.addra; dia = v.dia;
      enb = v.enb; web = v.web; addrb = v.addrb; dib = v.dib;
      for (int k = 0; k < 3; k++) begin
         e.due  = cyc + ((k == 1) ? 2 : 1);
         e.idx  = i;
         e.doa  = v.doa[k];
         e.dob  = v.dob[k];
         e.vala = v.vala[k];
         e.valb = v.valb[k];
         e.coll = v.coll;
         e.cdb  = v.cdb;
         if (k == 0) q0.push_back(e);
         else if (k == 1) q1.push_back(e);
         else q2.push_back(e);
      end
   endtask

   task automatic chk_idle_all(input string nm);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s u%0d rdy", nm, k), 32'(rdy[k]), 32'd0);
         chk($sformatf("%s u%0d vala", nm, k), 32'(vala[k]), 32'd0);
         chk($sformatf("%s u%0d valb", nm, k), 32'(valb[k]), 32'd0);
      end
   endtask

   initial begin
      logic [DW-1:0] rd_exp [8];
      int n;
      rd_exp = '{A5, A5, 32'h11BB_33DD, 32'h0000_5566, A5, 32'h0000_00F0, A5, A5};

      // Sweep reads after clear, then byte enables, RDW modes, collision, cross-port, range.
      for (int i = 0; i < 16; i++)
         tbl.push_back(mk(1, 4'h0, 5'(i), '0, 0, 4'h0, '0, '0, A5, A5, A5, 3'b111, '0, '0, '0, 3'b000, 0, 1));
      tbl.push_back(mk(1, 4'hF, 5'd2, 32'h1122_3344, 0, 4'h0, '0, '0,
                       32'h1122_3344, A5, A5, 3'b110, '0, '0, '0, 3'b000, 0, 1));
      tbl.push_back(mk(1, 4'h5, 5'd2, 32'hAABB_CCDD, 0, 4'h0, '0, '0,
                       32'h11BB_33DD, 32'h1122_3344, A5, 3'b110, '0, '0, '0, 3'b000, 0, 1));
      tbl.push_back(mk(1, 4'h0, 5'd2, '0, 0, 4'h0, '0, '0,
                       32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 3'b111, '0, '0, '0, 3'b000, 0, 1));
      tbl.push_back(mk(1, 4'hF, 5'd5, 32'h0000_000F, 0, 4'h0, '0, '0,
                       32'h0000_000F, A5, 32'h11BB_33DD, 3'b110, '0, '0, '0, 3'b000, 0, 1));
      tbl.push_back(mk(1, 4'hF, 5'd5, 32'h0000_00F0, 0, 4'h0, '0, '0,
                       32'h0000_00F0, 32'h0000_000F, 32'h11BB_33DD, 3'b110, '0, '0, '0, 3'b000, 0, 1));
      tbl.push_back(mk(1, 4'h3, 5'd3, 32'h0000_1111, 1, 4'h1, 5'd3, 32'h0000_2222,
                       32'h0000_1122, A5, 32'h11BB_33DD, 3'b110, 32'h0000_1122, A5, '0, 3'b110, 1, 1));
      tbl.push_back(mk(1, 4'h0, 5'd3, '0, 0, 4'h0, '0, '0,
                       32'h0000_1122, 32'h0000_1122, 32'h0000_1122, 3'b111, 32'h0000_1122, A5, '0, 3'b000, 0, 1));
      tbl.push_back(mk(1, 4'h3, 5'd3, 32'h0000_5566, 1, 4'h0, 5'd3, '0,
                       32'h0000_5566, 32'h0000_1122, 32'h0000_1122, 3'b110,
                       32'h0000_1122, 32'h0000_1122, 32'h0000_1122, 3'b111, 0, 1));
      tbl.push_back(mk(0, 4'h0, '0, '0, 1, 4'h0, 5'd3, '0,
                       32'h0000_5566, 32'h0000_1122, 32'h0000_1122, 3'b000,
                       32'h0000_5566, 32'h0000_5566, 32'h0000_5566, 3'b111, 0, 1));
      tbl.push_back(mk(1, 4'h0, 5'd20, '0, 1, 4'hF, 5'd20, 32'hDEAD_BEEF,
                       '0, '0, '0, 3'b111, '0, '0, '0, 3'b110, 0, 0));
      tbl.push_back(mk(1, 4'h0, 5'd4, '0, 1, 4'h0, 5'd3, '0,
                       A5, A5, A5, 3'b111, 32'h0000_5566, 32'h0000_5566, 32'h0000_5566, 3'b111, 0, 1));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 4'h0, 5'(i), '0, 0, 4'h0, '0, '0, rd_exp[i], rd_exp[i], rd_exp[i], 3'b111,
                          32'h0000_5566, 32'h0000_5566, 32'h0000_5566, 3'b000, 0, 1));
      tbl.push_back(mk(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, A5, A5, A5, 3'b000,
                       32'h0000_5566, 32'h0000_5566, 32'h0000_5566, 3'b000, 0, 1));

      rst_n = 1'b0; ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
      addra = '0; addrb = '0; dia = '0; dib = '0;
      repeat (3) begin
         tick;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset u%0d doa", k), doa[k], '0);
            chk($sformatf("reset u%0d dob", k), dob[k], '0);
            chk($sformatf("reset u%0d coll", k), 32'(coll[k]), 32'd0);
         end
         chk_idle_all("reset");
      end

      // Ops offered while not ready must be ignored.
      ena = 1'b1; wea = 4'hF; addra = 5'd9; dia = 32'hBAD0_BAD0;
      enb = 1'b1; web = 4'h0; addrb = 5'd9;
      rst_n = 1'b1;
      tick;
      chk("post-reset doa", doa[0], '0);
      chk_idle_all("post-reset");
      repeat (8) begin tick; chk_idle_all("clear"); end
      rst_n = 1'b0;
      tick; tick;
      chk_idle_all("mid-clear reset");
      rst_n = 1'b1;
      tick;
      n = 0;
      while (n < 40) begin
         tick;
         n++;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("restart u%0d vala", k), 32'(vala[k]), 32'd0);
            chk($sformatf("restart u%0d valb", k), 32'(valb[k]), 32'd0);
         end
         if (rdy[0]) break;
      end
      ena = 1'b0; enb = 1'b0; wea = '0;
      chk("rdy latency", 32'(n), 32'd17);
      chk("u1 rdy", 32'(rdy[1]), 32'd1);
      chk("u2 rdy", 32'(rdy[2]), 32'd1);

      foreach (tbl[i]) begin
         drive(tbl[i], i);
         tick;
      end
      ena = 1'b0; enb = 1'b0;
      repeat (3) tick;
      chk("scoreboard drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
